// File: rtl/ps2_key_pkg.sv
// Shared scan-code constants, key bit indices and FSM encoding for the PS/2 key tracker.
package ps2_key_pkg;

    localparam int NUM_KEYS = 10;

    localparam logic [7:0] CODE_EXT      = 8'hE0;
    localparam logic [7:0] CODE_BRK      = 8'hF0;
    localparam logic [7:0] CODE_PAUSE    = 8'hE1;
    localparam logic [7:0] CODE_ERR_00   = 8'h00;
    localparam logic [7:0] CODE_BAT_OK   = 8'hAA;
    localparam logic [7:0] CODE_BAT_FAIL = 8'hFC;
    localparam logic [7:0] CODE_ERR_FF   = 8'hFF;

    localparam logic [3:0] KEY_W     = 4'd0;
    localparam logic [3:0] KEY_A     = 4'd1;
    localparam logic [3:0] KEY_S     = 4'd2;
    localparam logic [3:0] KEY_D     = 4'd3;
    localparam logic [3:0] KEY_UP    = 4'd4;
    localparam logic [3:0] KEY_LEFT  = 4'd5;
    localparam logic [3:0] KEY_DOWN  = 4'd6;
    localparam logic [3:0] KEY_RIGHT = 4'd7;
    localparam logic [3:0] KEY_ENTER = 4'd8;
    localparam logic [3:0] KEY_ESC   = 4'd9;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_EXT     = 3'd1,
        ST_BRK     = 3'd2,
        ST_EXT_BRK = 3'd3,
        ST_SKIP    = 3'd4
    } state_t;

    // Keyboard self-test / overrun codes: any of these invalidates the held-key picture.
    function automatic logic is_error_code(input logic [7:0] code);
        return (code == CODE_ERR_00) || (code == CODE_BAT_OK) ||
               (code == CODE_BAT_FAIL) || (code == CODE_ERR_FF);
    endfunction

endpackage

// File: rtl/ps2_code_lookup.sv
// Combinational map from {extended flag, scan code} to a key_down bit index.
module ps2_code_lookup
    import ps2_key_pkg::*;
(
    input  logic       ext,
    input  logic [7:0] code,
    output logic       hit,
    output logic [3:0] index
);

    always_comb begin
        hit   = 1'b1;
        index = 4'd0;
        case ({ext, code})
            9'h01D:  index = KEY_W;
            9'h01C:  index = KEY_A;
            9'h01B:  index = KEY_S;
            9'h023:  index = KEY_D;
            9'h175:  index = KEY_UP;
            9'h16B:  index = KEY_LEFT;
            9'h172:  index = KEY_DOWN;
            9'h174:  index = KEY_RIGHT;
            9'h05A:  index = KEY_ENTER;
            9'h076:  index = KEY_ESC;
            default: hit   = 1'b0;
        endcase
    end

endmodule

// File: rtl/ps2_key_tracker.sv
// Parses E0/F0/E1 prefixed PS/2 scan-code sequences into a held-key level vector
// plus a one-cycle change event carrying the changed bit and its direction.
module ps2_key_tracker
    import ps2_key_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 100_000,
    parameter int E1_SKIP        = 7
)(
    input  logic                clk,
    input  logic                rst_n,
    input  logic [7:0]          rx_data,
    input  logic                rx_valid,
    output logic [NUM_KEYS-1:0] key_down,
    output logic                key_event,
    output logic [3:0]          key_index,
    output logic                key_make
);

    localparam int PCW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int SCW = (E1_SKIP > 1) ? $clog2(E1_SKIP + 1) : 1;
    localparam logic [PCW-1:0] PREFIX_LAST = PCW'(TIMEOUT_CYCLES - 1);
    localparam logic [SCW-1:0] SKIP_LOAD   = SCW'(E1_SKIP);

    state_t                state_reg, state_next;
    logic [PCW-1:0]        prefix_cnt_reg, prefix_cnt_next;
    logic [SCW-1:0]        skip_cnt_reg, skip_cnt_next;
    logic [NUM_KEYS-1:0]   key_down_reg, key_down_next;
    logic                  key_event_reg, key_event_next;
    logic [3:0]            key_index_reg, key_index_next;
    logic                  key_make_reg, key_make_next;

    logic                  lookup_ext;
    logic                  lookup_hit;
    logic [3:0]            lookup_index;
    logic                  apply_key;
    logic                  apply_make;

    assign lookup_ext = (state_reg == ST_EXT) || (state_reg == ST_EXT_BRK);

    ps2_code_lookup u_lookup (
        .ext   (lookup_ext),
        .code  (rx_data),
        .hit   (lookup_hit),
        .index (lookup_index)
    );

    // Sequence parsing: decides the next state and whether this byte completes a make/break.
    always_comb begin
        state_next      = state_reg;
        prefix_cnt_next = prefix_cnt_reg;
        skip_cnt_next   = skip_cnt_reg;
        apply_key       = 1'b0;
        apply_make      = 1'b0;

        if (rx_valid) begin
            prefix_cnt_next = '0;
            if (is_error_code(rx_data)) begin
                state_next    = ST_IDLE;
                skip_cnt_next = '0;
            end else begin
                case (state_reg)
                    ST_IDLE: begin
                        if (rx_data == CODE_EXT) begin
                            state_next = ST_EXT;
                        end else if (rx_data == CODE_BRK) begin
                            state_next = ST_BRK;
                        end else if (rx_data == CODE_PAUSE) begin
                            state_next    = ST_SKIP;
                            skip_cnt_next = SKIP_LOAD;
                        end else begin
                            apply_key  = 1'b1;
                            apply_make = 1'b1;
                        end
                    end
                    ST_EXT: begin
                        if (rx_data == CODE_BRK) begin
                            state_next = ST_EXT_BRK;
                        end else begin
                            apply_key  = 1'b1;
                            apply_make = 1'b1;
                            state_next = ST_IDLE;
                        end
                    end
                    ST_BRK, ST_EXT_BRK: begin
                        apply_key  = 1'b1;
                        state_next = ST_IDLE;
                    end
                    ST_SKIP: begin
                        if (skip_cnt_reg <= SCW'(1)) begin
                            skip_cnt_next = '0;
                            state_next    = ST_IDLE;
                        end else begin
                            skip_cnt_next = skip_cnt_reg - SCW'(1);
                        end
                    end
                    default: state_next = ST_IDLE;
                endcase
            end
        end else if (state_reg != ST_IDLE) begin
            // A byte arriving on the expiry cycle takes the branch above, so it wins.
            if (prefix_cnt_reg == PREFIX_LAST) begin
                state_next      = ST_IDLE;
                prefix_cnt_next = '0;
                skip_cnt_next   = '0;
            end else begin
                prefix_cnt_next = prefix_cnt_reg + PCW'(1);
            end
        end
    end

    // Key vector and event: only a real bit change produces an event.
    always_comb begin
        key_down_next  = key_down_reg;
        key_event_next = 1'b0;
        key_index_next = key_index_reg;
        key_make_next  = key_make_reg;

        if (rx_valid && is_error_code(rx_data)) begin
            key_down_next = '0;
        end else if (apply_key && lookup_hit &&
                     (key_down_reg[lookup_index] != apply_make)) begin
            key_down_next[lookup_index] = apply_make;
            key_event_next              = 1'b1;
            key_index_next              = lookup_index;
            key_make_next               = apply_make;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= ST_IDLE;
            prefix_cnt_reg <= '0;
            skip_cnt_reg   <= '0;
            key_down_reg   <= '0;
            key_event_reg  <= 1'b0;
            key_index_reg  <= 4'd0;
            key_make_reg   <= 1'b0;
        end else begin
            state_reg      <= state_next;
            prefix_cnt_reg <= prefix_cnt_next;
            skip_cnt_reg   <= skip_cnt_next;
            key_down_reg   <= key_down_next;
            key_event_reg  <= key_event_next;
            key_index_reg  <= key_index_next;
            key_make_reg   <= key_make_next;
        end
    end

    assign key_down  = key_down_reg;
    assign key_event = key_event_reg;
    assign key_index = key_index_reg;
    assign key_make  = key_make_reg;

endmodule

// File: tb/tb_ps2_key_tracker.sv
// Directed scan-code sequences against hand-computed key_down / event expectations.
module tb_ps2_key_tracker;

    localparam int TO = 16;

    logic       clk;
    logic       rst_n;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [9:0] key_down;
    logic       key_event;
    logic [3:0] key_index;
    logic       key_make;

    int n_cmp;
    int n_err;

    ps2_key_tracker #(
        .TIMEOUT_CYCLES (TO),
        .E1_SKIP        (7)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .key_down  (key_down),
        .key_event (key_event),
        .key_index (key_index),
        .key_make  (key_make)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    // Called at a negedge; presents one byte for one cycle and returns at the next negedge.
    task automatic send(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        rx_data  = 8'h00;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_evt(input string tag, input logic [9:0] kd, input logic [3:0] idx,
                             input logic mk);
        check({tag, ".kd"},  32'(key_down),  32'(kd));
        check({tag, ".evt"}, 32'(key_event), 32'd1);
        check({tag, ".idx"}, 32'(key_index), 32'(idx));
        check({tag, ".mk"},  32'(key_make),  32'(mk));
    endtask

    initial begin
        logic [7:0] pause_seq [8];
        n_cmp    = 0;
        n_err    = 0;
        rst_n    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        idle(3);
        rst_n = 1'b1;
        idle(1);

        check("rst.kd",  32'(key_down),  32'h0);
        check("rst.evt", 32'(key_event), 32'h0);
        check("rst.idx", 32'(key_index), 32'h0);
        check("rst.mk",  32'(key_make),  32'h0);

        // LEFT press / release
        send(8'hE0);
        check("left_pfx.evt", 32'(key_event), 32'd0);
        send(8'h6B);
        check_evt("left_make", 10'h020, 4'd5, 1'b1);
        idle(1);
        check("left_pulse_end", 32'(key_event), 32'd0);
        send(8'hE0); send(8'hF0); send(8'h6B);
        check_evt("left_break", 10'h000, 4'd5, 1'b0);

        // Typematic W
        send(8'h1D);
        check_evt("w_make", 10'h001, 4'd0, 1'b1);
        send(8'h1D);
        check("w_rep1.evt", 32'(key_event), 32'd0);
        send(8'h1D);
        check("w_rep2.evt", 32'(key_event), 32'd0);
        check("w_rep2.kd",  32'(key_down),  32'h001);
        send(8'hF0); send(8'h1D);
        check_evt("w_break", 10'h000, 4'd0, 1'b0);

        // Combo UP + RIGHT, release UP, then ENTER
        send(8'hE0); send(8'h75);
        check_evt("up_make", 10'h010, 4'd4, 1'b1);
        send(8'hE0); send(8'h74);
        check_evt("right_make", 10'h090, 4'd7, 1'b1);
        send(8'hE0); send(8'hF0); send(8'h75);
        check_evt("up_break", 10'h080, 4'd4, 1'b0);
        send(8'h5A);
        check_evt("enter_make", 10'h180, 4'd8, 1'b1);

        // AA with keys held: clear, no event, index/make held
        send(8'hAA);
        check("aa.kd",  32'(key_down),  32'h000);
        check("aa.evt", 32'(key_event), 32'd0);
        check("aa.idx", 32'(key_index), 32'd8);
        check("aa.mk",  32'(key_make),  32'd1);

        // Break of a key not held
        send(8'hF0); send(8'h76);
        check("brk_unheld.evt", 32'(key_event), 32'd0);
        check("brk_unheld.kd",  32'(key_down),  32'h000);

        // Timeout: full idle window drops E0
        send(8'hE0);
        idle(TO);
        send(8'h75);
        check("to_expired.kd",  32'(key_down),  32'h000);
        check("to_expired.evt", 32'(key_event), 32'd0);
        // Byte on the expiry cycle wins
        send(8'hE0);
        idle(TO - 1);
        send(8'h75);
        check_evt("to_edge", 10'h010, 4'd4, 1'b1);

        // Pause sequence: no effect
        pause_seq = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
        for (int i = 0; i < 8; i++) begin
            send(pause_seq[i]);
            check($sformatf("pause[%0d].evt", i), 32'(key_event), 32'd0);
        end
        check("pause.kd", 32'(key_down), 32'h010);
        send(8'h76);
        check_evt("esc_make", 10'h210, 4'd9, 1'b1);

        // Error code inside a prefix drops the sequence
        send(8'hE0); send(8'hFF);
        check("pfx_err.kd",  32'(key_down),  32'h000);
        check("pfx_err.evt", 32'(key_event), 32'd0);
        send(8'h1D);
        check_evt("after_pfx_err", 10'h001, 4'd0, 1'b1);

        // Asynchronous reset mid E0 F0
        send(8'hE0); send(8'hF0);
        #2 rst_n = 1'b0;
        #1;
        check("arst.kd",  32'(key_down),  32'h0);
        check("arst.evt", 32'(key_event), 32'h0);
        check("arst.idx", 32'(key_index), 32'h0);
        check("arst.mk",  32'(key_make),  32'h0);
        idle(2);
        rst_n = 1'b1;
        idle(1);
        send(8'h74);
        check("post_rst74.kd",  32'(key_down),  32'h000);
        check("post_rst74.evt", 32'(key_event), 32'd0);
        send(8'h1D);
        check_evt("post_rst_w", 10'h001, 4'd0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
